matrix_loader: RTL and testbench

Upstream load stage for `matrix_mul`. It accepts a serial valid/ready stream of matrix elements: all of A row-major, then all of B. Each element is written into internal storage. When both MATRIX_SIZE×MATRIX_SIZE operands are complete, it presents them as flat buses with a valid/ready handoff to the multiplier. Storage is single-buffered, so loading of the next operand pair starts only after the consumer accepts the current pair.

---
 rtl/matrix_pkg.sv | 16 +
 rtl/matrix_store.sv | 38 +++
 rtl/matrix_loader.sv | 134 +++++++++++++
 tb/tb_matrix_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix pipeline (loader, multiplier, result drain):
// operand-load FSM states and the element-count helper.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  // Elements per N x N matrix.
  function automatic int nn(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/matrix_store.sv
// One N x N register bank: writes one element per cycle at (row, col) and
// exposes the whole matrix as a flat row-major bus.
module matrix_store
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               we,
  input  logic [$clog2(MATRIX_SIZE)-1:0]                     row,
  input  logic [$clog2(MATRIX_SIZE)-1:0]                     col,
  input  logic [DATA_WIDTH-1:0]                              data,
  output logic [nn(MATRIX_SIZE)*DATA_WIDTH-1:0]              flat
);

  localparam int NN = nn(MATRIX_SIZE);
  localparam int IW = $clog2(NN);

  logic [DATA_WIDTH-1:0] mem [NN];
  logic [IW-1:0]         addr;

  assign addr = IW'(row) * IW'(MATRIX_SIZE) + IW'(col);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= data;
    end
  end

  for (genvar g = 0; g < NN; g++) begin : g_flat
    assign flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/matrix_loader.sv
// Serial-to-parallel operand loader for matrix_mul: streams A then B into
// single-buffered storage and hands the pair off with valid/ready.
// Define MATRIX_LOADER_B_COLMAJOR_EN to accept B beats in column-major order.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_WIDTH-1:0]                       in_data,
  input  logic                                        in_last,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [nn(MATRIX_SIZE)*DATA_WIDTH-1:0]       a_flat,
  output logic [nn(MATRIX_SIZE)*DATA_WIDTH-1:0]       b_flat,
  output logic                                        err
);

  localparam int NN = nn(MATRIX_SIZE);
  localparam int IW = $clog2(NN);
  localparam int AW = $clog2(MATRIX_SIZE);

  state_t        state;
  logic [IW-1:0] idx;
  logic          ready_q;
  logic          beat;
  logic          idx_last;
  logic [AW-1:0] idx_row;
  logic [AW-1:0] idx_col;
  logic [AW-1:0] b_row;
  logic [AW-1:0] b_col;

  // ready_q keeps in_ready low through reset and releases it on the first edge after.
  assign in_ready = ready_q && (state != FULL);
  assign beat     = in_valid && in_ready;
  assign idx_last = (idx == IW'(NN - 1));
  assign idx_row  = AW'(idx / IW'(MATRIX_SIZE));
  assign idx_col  = AW'(idx % IW'(MATRIX_SIZE));

`ifdef MATRIX_LOADER_B_COLMAJOR_EN
  assign b_row = idx_col;
  assign b_col = idx_row;
`else
  assign b_row = idx_row;
  assign b_col = idx_col;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= LOAD_A;
      idx       <= '0;
      ready_q   <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err     <= 1'b0;
      case (state)
        LOAD_A: begin
          if (beat) begin
            if (in_last) begin
              err <= 1'b1;
              idx <= '0;
            end else if (idx_last) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOAD_B: begin
          // A complete B goes to FULL even if the frame marker was missing.
          if (beat) begin
            if (idx_last) begin
              idx       <= '0;
              state     <= FULL;
              out_valid <= 1'b1;
              err       <= !in_last;
            end else if (in_last) begin
              err   <= 1'b1;
              idx   <= '0;
              state <= LOAD_A;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= LOAD_A;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD_A;
          idx       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  matrix_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATRIX_SIZE(MATRIX_SIZE)
  ) u_store_a (
    .clock(clock),
    .reset(reset),
    .we   (beat && (state == LOAD_A)),
    .row  (idx_row),
    .col  (idx_col),
    .data (in_data),
    .flat (a_flat)
  );

  matrix_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATRIX_SIZE(MATRIX_SIZE)
  ) u_store_b (
    .clock(clock),
    .reset(reset),
    .we   (beat && (state == LOAD_B)),
    .row  (b_row),
    .col  (b_col),
    .data (in_data),
    .flat (b_flat)
  );

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader (N=3, 8-bit): stimulus pushes expected
// operand pairs, a monitor pops and compares on each out_valid rise.
module tb_matrix_loader;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int FW = NN * DW;

  typedef struct packed {
    logic [FW-1:0] a;
    logic [FW-1:0] b;
  } pair_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] a_flat;
  logic [FW-1:0] b_flat;
  logic          err;

  int    vectors     = 0;
  int    miscompares = 0;
  int    err_seen    = 0;
  int    err_exp     = 0;
  logic  prev_valid  = 1'b0;
  pair_t exp_q[$];
  pair_t cur_exp;

  matrix_loader #(.DATA_WIDTH(DW), .MATRIX_SIZE(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] modelA(input int base);
    logic [FW-1:0] r = '0;
    for (int k = 0; k < NN; k++) r[k*DW +: DW] = DW'(base + k);
    return r;
  endfunction

  function automatic logic [FW-1:0] modelB(input int base);
    logic [FW-1:0] r = '0;
    int pos;
    for (int k = 0; k < NN; k++) begin
`ifdef MATRIX_LOADER_B_COLMAJOR_EN
      pos = (k % N) * N + (k / N);
`else
      pos = k;
`endif
      r[pos*DW +: DW] = DW'(base + NN + k);
    end
    return r;
  endfunction

  // Drives one beat and holds it until the DUT accepts it; returns #1 after the accepting edge.
  task automatic sendBeat(input logic [DW-1:0] v, input logic l);
    int waited = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = l;
    while (!done) begin
      @(negedge clock);
      if (in_ready) done = 1;
      @(posedge clock);
      #1;
      if (!done) begin
        waited++;
        if (waited > 50) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL accept_timeout: beat %0h not accepted, in_ready=%0b required 1", v, in_ready);
          done = 1;
        end
      end
    end
  endtask

  // Sends a pair starting at value base; early >= 0 aborts with in_last on that beat.
  task automatic applyStimulus(input int base, input int early, input bit last_on_final, input int beats);
    pair_t p;
    if (early < 0 && beats == 2 * NN) begin
      p.a = modelA(base);
      p.b = modelB(base);
      exp_q.push_back(p);
      cur_exp = p;
    end
    if (early >= 0 || (beats == 2 * NN && !last_on_final)) err_exp++;
    for (int k = 0; k < beats; k++) begin
      sendBeat(DW'(base + k), (k == early) || (k == 2 * NN - 1 && last_on_final));
      if (k == early) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checkOutput("handoff_out_valid", FW'(out_valid), FW'(0));
    checkOutput("handoff_in_ready", FW'(in_ready), FW'(1));
  endtask

  // Monitor: pops the expected pair on every out_valid rise and tallies err pulses.
  always @(negedge clock) begin
    pair_t p;
    if (reset && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pair: out_valid=1 required 0");
      end else begin
        p = exp_q.pop_front();
        checkOutput("pair_a_flat", a_flat, p.a);
        checkOutput("pair_b_flat", b_flat, p.b);
      end
    end
    prev_valid = out_valid;
    if (err) err_seen++;
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_ready", FW'(in_ready), FW'(0));
    checkOutput("rst_out_valid", FW'(out_valid), FW'(0));
    checkOutput("rst_err", FW'(err), FW'(0));
    checkOutput("rst_a_flat", a_flat, '0);
    checkOutput("rst_b_flat", b_flat, '0);
    reset = 1'b1;
    #1;
    checkOutput("release_in_ready", FW'(in_ready), FW'(0));
    @(posedge clock);
    #1;
    checkOutput("post_release_in_ready", FW'(in_ready), FW'(1));

    $display("[TB] back-to-back load 1..18");
    applyStimulus(1, -1, 1'b1, 2 * NN);
    checkOutput("load1_out_valid", FW'(out_valid), FW'(1));
    checkOutput("load1_in_ready", FW'(in_ready), FW'(0));
    checkOutput("load1_a00", FW'(a_flat[0 +: DW]), FW'(1));
    checkOutput("load1_a22", FW'(a_flat[8*DW +: DW]), FW'(9));
    checkOutput("load1_b00", FW'(b_flat[0 +: DW]), FW'(10));
    checkOutput("load1_b22", FW'(b_flat[8*DW +: DW]), FW'(18));
    @(negedge clock);
    checkOutput("load1_no_err", FW'(err_seen), FW'(0));

    $display("[TB] backpressure with random in_valid");
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'hEE;
      @(posedge clock);
      #1;
      checkOutput("bp_in_ready", FW'(in_ready), FW'(0));
      checkOutput("bp_out_valid", FW'(out_valid), FW'(1));
      checkOutput("bp_a_flat", a_flat, cur_exp.a);
      checkOutput("bp_b_flat", b_flat, cur_exp.b);
    end
    in_valid = 1'b0;

    handoff();
    $display("[TB] second load 101..118");
    applyStimulus(101, -1, 1'b1, 2 * NN);
    checkOutput("load2_a00", FW'(a_flat[0 +: DW]), FW'(101));
    handoff();

    $display("[TB] early in_last on beat 5");
    applyStimulus(151, 4, 1'b1, 2 * NN);
    checkOutput("early_err", FW'(err), FW'(1));
    checkOutput("early_out_valid", FW'(out_valid), FW'(0));
    @(posedge clock);
    #1;
    checkOutput("early_err_drop", FW'(err), FW'(0));
    applyStimulus(201, -1, 1'b1, 2 * NN);
    checkOutput("after_early_a00", FW'(a_flat[0 +: DW]), FW'(201));
    handoff();

    $display("[TB] missing in_last");
    applyStimulus(51, -1, 1'b0, 2 * NN);
    checkOutput("missing_err", FW'(err), FW'(1));
    checkOutput("missing_out_valid", FW'(out_valid), FW'(1));
    handoff();

    $display("[TB] reset after beat 12");
    applyStimulus(1, -1, 1'b1, 12);
    reset = 1'b0;
    #1;
    checkOutput("midrst_in_ready", FW'(in_ready), FW'(0));
    checkOutput("midrst_out_valid", FW'(out_valid), FW'(0));
    checkOutput("midrst_err", FW'(err), FW'(0));
    checkOutput("midrst_a_flat", a_flat, '0);
    checkOutput("midrst_b_flat", b_flat, '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] B layout check after reset");
    applyStimulus(1, -1, 1'b1, 2 * NN);
`ifdef MATRIX_LOADER_B_COLMAJOR_EN
    checkOutput("b10_layout", FW'(b_flat[3*DW +: DW]), FW'(11));
`else
    checkOutput("b10_layout", FW'(b_flat[3*DW +: DW]), FW'(13));
`endif
    handoff();
    repeat (2) @(negedge clock);

    checkOutput("err_pulses", FW'(err_seen), FW'(err_exp));
    checkOutput("queue_drained", FW'(exp_q.size()), FW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
